// File: rtl/capi_mmio_pkg.sv
// Shared MMIO definitions: master state encoding, bus field positions of the
// packed {vld,cfg,rnw,dw,addr,wd} bus, and the latched request record.
package capi_mmio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_WACK  = 3'd2,
        ST_RWAIT = 3'd3,
        ST_RACK  = 3'd4
    } state_t;

    localparam int WD_LSB   = 0;
    localparam int WD_W     = 64;
    localparam int ADDR_LSB = WD_LSB + WD_W;

    // Header bit positions depend on the address width chosen by the master.
    function automatic int dw_pos(input int aw);
        return ADDR_LSB + aw;
    endfunction

    function automatic int rnw_pos(input int aw);
        return ADDR_LSB + aw + 1;
    endfunction

    function automatic int cfg_pos(input int aw);
        return ADDR_LSB + aw + 2;
    endfunction

    function automatic int vld_pos(input int aw);
        return ADDR_LSB + aw + 3;
    endfunction

    typedef struct packed {
        logic        dw;
        logic        perr;
        logic [63:0] wd;
    } req_t;

endpackage

// File: rtl/capi_mmio_par.sv
// 64-bit odd-parity generator: par makes the total count of ones odd.
module capi_mmio_par (
    input  logic [63:0] data,
    output logic        par
);
    assign par = ~^data;
endmodule

// File: rtl/capi_mmio_master.sv
// CAPI MMIO master: turns host MMIO strobes into header/data bus cycles and
// returns one ack per request. Optional parity via CAPI_MMIO_PARITY_EN.
module capi_mmio_master
    import capi_mmio_pkg::*;
#(
    parameter int addr_width    = 24,
    parameter int mmiobus_width = 4 + addr_width + 64,
    parameter int timeout       = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_ha_mmval,
    input  logic                     i_ha_mmcfg,
    input  logic                     i_ha_mmrnw,
    input  logic                     i_ha_mmdw,
    input  logic [addr_width-1:0]    i_ha_mmad,
    input  logic [63:0]              i_ha_mmdata,
    input  logic                     i_ha_mmdatapar,
    input  logic                     i_rd_v,
    input  logic [63:0]              i_rd_d,
    output logic [mmiobus_width-1:0] o_mmiobus,
    output logic                     o_ah_mmack,
    output logic [63:0]              o_ah_mmdata,
    output logic                     o_ah_mmdatapar,
    output logic                     o_perr,
    output logic                     o_err_sticky
);
    localparam int VLD = vld_pos(addr_width);
    localparam int CFG = cfg_pos(addr_width);
    localparam int RNW = rnw_pos(addr_width);
    localparam int DW  = dw_pos(addr_width);

    state_t                   state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    req_t                     req_q;
    logic [mmiobus_width-1:0] bus_q, bus_d;
    logic                     ack_q, ack_d;
    logic [63:0]              data_q, data_d;
    logic                     par_q, par_d;
    logic                     perr_q, perr_d;
    logic                     err_q;
    logic                     bad_par, gen_par;

`ifdef CAPI_MMIO_PARITY_EN
    logic exp_par;

    capi_mmio_par u_par_chk (.data(i_ha_mmdata), .par(exp_par));
    capi_mmio_par u_par_gen (.data(data_d),      .par(gen_par));

    assign bad_par = exp_par != i_ha_mmdatapar;
`else
    logic unused_datapar;

    assign unused_datapar = i_ha_mmdatapar;
    assign bad_par        = 1'b0;
    assign gen_par        = 1'b0;
`endif

    assign par_d = ack_d & gen_par;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = '0;
        ack_d   = 1'b0;
        data_d  = '0;
        perr_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (i_ha_mmval) begin
                // A write with bad parity still runs its cycles but never strobes a target.
                bus_d[VLD]                       = i_ha_mmrnw | ~bad_par;
                bus_d[CFG]                       = i_ha_mmcfg;
                bus_d[RNW]                       = i_ha_mmrnw;
                bus_d[DW]                        = i_ha_mmdw;
                bus_d[ADDR_LSB +: addr_width]    = i_ha_mmad;
                cnt_d                            = '0;
                state_d = i_ha_mmrnw ? ST_RWAIT : ST_WDATA;
            end
            ST_WDATA: begin
                bus_d[WD_LSB +: WD_W] = req_q.wd;
                state_d               = ST_WACK;
            end
            ST_WACK: begin
                ack_d   = 1'b1;
                perr_d  = req_q.perr;
                state_d = ST_IDLE;
            end
            ST_RWAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (i_rd_v) begin
                    ack_d   = 1'b1;
                    data_d  = req_q.dw ? i_rd_d : {2{i_rd_d[31:0]}};
                    state_d = ST_RACK;
                end else if (cnt_q == 8'(timeout)) begin
                    ack_d   = 1'b1;
                    data_d  = '1;
                    state_d = ST_RACK;
                end
            end
            ST_RACK: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q <= '0;
        end else if (state_q == ST_IDLE && i_ha_mmval) begin
            req_q <= '{dw: i_ha_mmdw, perr: bad_par & ~i_ha_mmrnw, wd: i_ha_mmdata};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bus_q   <= '0;
            ack_q   <= 1'b0;
            data_q  <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            if (i_ha_mmval && state_q != ST_IDLE) err_q <= 1'b1;
        end
    end

    assign o_mmiobus      = bus_q;
    assign o_ah_mmack     = ack_q;
    assign o_ah_mmdata    = data_q;
    assign o_ah_mmdatapar = par_q;
    assign o_perr         = perr_q;
    assign o_err_sticky   = err_q;

endmodule
